mc_control_fsm: RTL and testbench
=================================

# mc_control_fsm

Multi-cycle control FSM for the RV32I core: the sequential successor to the single-cycle opcode decoder. It sequences each instruction through fetch, decode, execute, memory and write-back states over a shared instruction/data memory with a req/ready handshake, and drives datapath mux selects and register enables per state. It sits between the instruction register, ALU and memory port. Illegal opcodes and memory timeouts latch a trap state.

## Interface
- `MEM_TIMEOUT`, 16: max cycles `mem_req` may wait for `mem_ready` (1..2^TO_W-1).
- `TO_W`, 5: timeout counter width.
- `CNT_W`, 32: performance counter width (perf build only).

Ports. Single clock; reset is synchronous and active-low.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: synchronous active-low reset.
- `instr` in 32: IR contents; bits [6:0] are the opcode.
- `mem_ready` in 1: memory completes the request this cycle.
- `branch_taken` in 1: ALU compare result for the current branch.
- `mem_req` out 1: memory request.
- `mem_we` out 1: write request.
- `addr_sel` out 1: 0 = PC, 1 = ALUOut register.
- `ir_write` out 1: load IR.
- `pc_write` out 1: load PC.
- `pc_src` out 2: 0 = ALU result, 1 = ALUOut register.
- `alu_a_sel` out 2: 0 = rs1, 1 = PC, 2 = oldPC, 3 = zero.
- `alu_b_sel` out 2: 0 = rs2, 1 = imm, 2 = const 4.
- `alu_op` out 2: 00 = add, 01 = branch compare, 10 = funct decode.
- `reg_write` out 1: register file write.
- `wb_sel` out 2: 0 = ALUOut, 1 = MDR, 2 = PC.
- `retire` out 1: one-cycle pulse on instruction completion.
- `trap` out 1: sticky error flag.
- `trap_cause` out 2: 1 = illegal opcode, 2 = memory timeout.
- `state` out 3: current state, for debug.
- `perf_cycles`, `perf_retired` out CNT_W: performance counters (perf build only).

## Operation
States:
- FETCH
  - Drives `mem_req`=1, `addr_sel`=0, `alu_a_sel`=1, `alu_b_sel`=2, `alu_op`=00.
  - On `mem_ready`: `ir_write`=1, `pc_write`=1, `pc_src`=0, then DECODE.
- DECODE
  - Drives `alu_a_sel`=2, `alu_b_sel`=1 so the branch/JAL target reaches ALUOut.
  - Dispatches on opcode:
    - 0110011, 0010011, 0000011, 0100011, 0110111, 0010111 → EXEC.
    - 1100011 (branch): BRANCH.
    - 1101111 (JAL), 1100111 (JALR): JUMP.
    - Any other opcode → TRAP with cause 1.
- EXEC
  - R-type: `alu_a_sel`=0, `alu_b_sel`=0, `alu_op`=10.
  - I-arith: `alu_a_sel`=0, `alu_b_sel`=1, `alu_op`=10.
  - Load/store: `alu_a_sel`=0, `alu_b_sel`=1, `alu_op`=00.
  - LUI: `alu_a_sel`=3, `alu_b_sel`=1. AUIPC: `alu_a_sel`=2, `alu_b_sel`=1.
  - Next state: MEM for loads/stores, otherwise WB.
- MEM
  - Drives `mem_req`=1, `addr_sel`=1, and `mem_we`=1 for stores.
  - On `mem_ready`: loads go to WB; stores go to FETCH with `retire`.
- WB
  - `reg_write`=1; `wb_sel`=1 for loads, 0 otherwise.
  - Pulses `retire`, then FETCH.
- BRANCH
  - Drives `alu_a_sel`=0, `alu_b_sel`=0, `alu_op`=01.
  - If `branch_taken`: `pc_write`=1, `pc_src`=1.
  - Pulses `retire`, then FETCH.
- JUMP
  - `reg_write`=1, `wb_sel`=2.
  - `pc_write`=1.
  - JAL: `pc_src`=1.
  - JALR: `alu_a_sel`=0, `alu_b_sel`=1, `pc_src`=0; the datapath clears bit 0.
  - Pulses `retire`, then FETCH.
- TRAP
  - All enables 0; `trap`=1; `trap_cause` held.
  - Exits only on reset.

Rules:
- Every output not listed for a state is 0.
- `mem_req`, `mem_we` and `addr_sel` stay stable until the `mem_ready` cycle.
- `mem_ready` outside FETCH or MEM is ignored.

## Timing
- Reset (`rst_n`=0 at an edge) gives:
  - state FETCH;
  - `trap`=0, `trap_cause`=0;
  - timeout counter 0;
  - perf counters 0;
  - all combinational outputs at their FETCH values, except `mem_req`, which is 0 during the reset cycle.
- Reset mid-memory-access abandons the request; the memory must tolerate a dropped request.
- Latency in cycles with zero-wait memory:
  - ALU ops and LUI/AUIPC: 4.
  - Loads: 5.
  - Stores: 4.
  - Branches, JAL, JALR: 3.
  - Each memory wait cycle adds 1.
- Timeout counter:
  - Clears on entry to FETCH or MEM.
  - Increments each cycle `mem_req`=1 and `mem_ready`=0.
  - Reaching `MEM_TIMEOUT` enters TRAP with cause 2 on the next edge.
  - A `mem_ready` in the same cycle as the threshold wins: the access completes with no trap.
- `retire` is high for exactly 1 cycle per instruction, and never in TRAP.

## Configuration
- `MC_CTRL_PERF_EN` defined:
  - `perf_cycles` increments every cycle outside reset and TRAP.
  - `perf_retired` increments on `retire`.
  - Both wrap modulo 2^CNT_W.
- `MC_CTRL_PERF_EN` undefined: both ports are absent and no counter flops are built.

## Structure
- Package `mc_ctrl_pkg` holds:
  - the state enum (FETCH, DECODE, EXEC, MEM, WB, BRANCH, JUMP, TRAP);
  - the opcode constants;
  - the encodings for `alu_op`, the `*_sel` signals and `trap_cause`.
- Sub-module `mc_mem_timer` holds the timeout counter.
  - Inputs: `clk`, `rst_n`, `clear`, `waiting`.
  - Output: `expired`.

## Test plan
- R-type `add` (0x002081B3) with `mem_ready` always 1: states F, D, E, WB; `reg_write` in cycle 4; `retire` once.
- Load `lw` (0x0000A183) with 2 wait cycles in MEM: `mem_req`/`addr_sel`=1 held 3 cycles; `wb_sel`=1 in WB; total 7 cycles.
- Branch `beq`:
  - `branch_taken`=1 gives `pc_write`=1, `pc_src`=1 in cycle 3;
  - `branch_taken`=0 gives `pc_write`=0.
- Opcode 0x7F: TRAP with `trap_cause`=1 after DECODE; `mem_req` stays 0 for 20 cycles; `rst_n` low for 1 cycle returns to FETCH with `trap`=0.
- Memory timeout: `mem_ready` held 0 in FETCH with `MEM_TIMEOUT`=16: trap cause 2 after 16 wait cycles; `mem_ready`=1 on the 16th cycle gives no trap.
- Perf build: 10 `addi` instructions gives `perf_retired`=10 and `perf_cycles`=40.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared types and encodings for the multi-cycle RV32I control FSM.
// Holds the state enum, the RV32I major opcodes, the datapath select encodings
// and a helper that maps an opcode onto the state that follows DECODE.
package mc_ctrl_pkg;

  // Controller states; the numeric values are visible on the debug state port.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_BRANCH = 3'd5,
    ST_JUMP   = 3'd6,
    ST_TRAP   = 3'd7
  } state_e;

  // RV32I major opcodes (instr[6:0]).
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // ALU operation class.
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_BRCMP = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // ALU operand A source.
  localparam logic [1:0] A_RS1   = 2'd0;
  localparam logic [1:0] A_PC    = 2'd1;
  localparam logic [1:0] A_OLDPC = 2'd2;
  localparam logic [1:0] A_ZERO  = 2'd3;

  // ALU operand B source.
  localparam logic [1:0] B_RS2  = 2'd0;
  localparam logic [1:0] B_IMM  = 2'd1;
  localparam logic [1:0] B_FOUR = 2'd2;

  // PC source.
  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;

  // Memory address source.
  localparam logic ADDR_PC     = 1'b0;
  localparam logic ADDR_ALUOUT = 1'b1;

  // Register file write-back source.
  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;

  // Trap causes.
  localparam logic [1:0] TC_NONE    = 2'd0;
  localparam logic [1:0] TC_ILLEGAL = 2'd1;
  localparam logic [1:0] TC_TIMEOUT = 2'd2;

  // State entered after DECODE for a given opcode; unknown opcodes trap.
  function automatic state_e dispatch(input logic [6:0] opc);
    state_e nxt;
    case (opc)
      OPC_OP, OPC_OP_IMM, OPC_LOAD,
      OPC_STORE, OPC_LUI, OPC_AUIPC: nxt = ST_EXEC;
      OPC_BRANCH:                    nxt = ST_BRANCH;
      OPC_JAL, OPC_JALR:             nxt = ST_JUMP;
      default:                       nxt = ST_TRAP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mc_mem_timer.sv
// mc_mem_timer: counts cycles a memory request waits for ready.
// expired is high during the MEM_TIMEOUT-th consecutive wait cycle, so the
// controller traps at the end of that cycle; a ready in that same cycle is
// not a wait cycle and therefore wins over the timeout.
module mc_mem_timer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic waiting,
  output logic expired
);

  localparam logic [TO_W-1:0] LAST_WAIT = TO_W'(MEM_TIMEOUT - 1);

  logic [TO_W-1:0] r_count;

  // Wait counter: cleared on entry to an access state, advances on each wait.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignment so every flop samples pre-edge values.
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (waiting) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = waiting && (r_count == LAST_WAIT);

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle control FSM for the RV32I core.
// Sequences FETCH/DECODE/EXEC/MEM/WB (plus BRANCH, JUMP, TRAP) over a shared
// instruction/data memory with a req/ready handshake and drives the datapath
// mux selects and register enables for each state.
// Build option: define MC_CTRL_PERF_EN to add the perf_cycles/perf_retired
// counters (and the CNT_W parameter); without it neither exists.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5
`ifdef MC_CTRL_PERF_EN
  ,
  parameter int CNT_W       = 32
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic [1:0]       alu_a_sel,
  output logic [1:0]       alu_b_sel,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             retire,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [2:0]       state
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_cycles,
  output logic [CNT_W-1:0] perf_retired
`endif
);

  state_e     r_state;
  state_e     w_state_eff;
  state_e     w_next;
  logic [1:0] r_trap_cause;
  logic [1:0] w_cause_set;
  logic [6:0] w_opc;
  logic       w_is_load;
  logic       w_is_store;
  logic       w_waiting;
  logic       w_clear;
  logic       w_expired;
  logic       w_unused_instr;

  assign w_opc      = instr[6:0];
  assign w_is_load  = (w_opc == OPC_LOAD);
  assign w_is_store = (w_opc == OPC_STORE);

  // Only the opcode field steers the controller; funct fields go to the ALU.
  assign w_unused_instr = ^instr[31:7];

  // While reset is asserted the outputs present FETCH, whatever the register holds.
  assign w_state_eff = rst_n ? r_state : ST_FETCH;

  // State register with synchronous reset into FETCH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Trap cause latches on the transition into TRAP and holds until reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_trap_cause <= TC_NONE;
    end else if ((w_next == ST_TRAP) && (r_state != ST_TRAP)) begin
      r_trap_cause <= w_cause_set;
    end
  end

  // Next-state and per-state datapath controls.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    w_next      = r_state;
    w_cause_set = TC_NONE;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = ADDR_PC;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = PC_ALU;
    alu_a_sel   = A_RS1;
    alu_b_sel   = B_RS2;
    alu_op      = ALU_ADD;
    reg_write   = 1'b0;
    wb_sel      = WB_ALUOUT;
    retire      = 1'b0;

    case (w_state_eff)
      ST_FETCH: begin
        // Request is suppressed during reset; the PC+4 path is still presented.
        mem_req   = rst_n;
        addr_sel  = ADDR_PC;
        alu_a_sel = A_PC;
        alu_b_sel = B_FOUR;
        alu_op    = ALU_ADD;
        if (mem_ready && rst_n) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = PC_ALU;
          w_next   = ST_DECODE;
        end else if (w_expired) begin
          w_next      = ST_TRAP;
          w_cause_set = TC_TIMEOUT;
        end
      end

      ST_DECODE: begin
        // oldPC + imm lands in ALUOut as the branch/JAL target.
        alu_a_sel = A_OLDPC;
        alu_b_sel = B_IMM;
        w_next    = dispatch(w_opc);
        if (w_next == ST_TRAP) begin
          w_cause_set = TC_ILLEGAL;
        end
      end

      ST_EXEC: begin
        case (w_opc)
          OPC_OP: begin
            alu_a_sel = A_RS1;
            alu_b_sel = B_RS2;
            alu_op    = ALU_FUNCT;
          end
          OPC_OP_IMM: begin
            alu_a_sel = A_RS1;
            alu_b_sel = B_IMM;
            alu_op    = ALU_FUNCT;
          end
          OPC_LOAD, OPC_STORE: begin
            alu_a_sel = A_RS1;
            alu_b_sel = B_IMM;
            alu_op    = ALU_ADD;
          end
          OPC_LUI: begin
            alu_a_sel = A_ZERO;
            alu_b_sel = B_IMM;
          end
          OPC_AUIPC: begin
            alu_a_sel = A_OLDPC;
            alu_b_sel = B_IMM;
          end
          default: begin
          end
        endcase
        w_next = (w_is_load || w_is_store) ? ST_MEM : ST_WB;
      end

      ST_MEM: begin
        mem_req  = 1'b1;
        addr_sel = ADDR_ALUOUT;
        mem_we   = w_is_store;
        if (mem_ready) begin
          if (w_is_store) begin
            retire = 1'b1;
            w_next = ST_FETCH;
          end else begin
            w_next = ST_WB;
          end
        end else if (w_expired) begin
          w_next      = ST_TRAP;
          w_cause_set = TC_TIMEOUT;
        end
      end

      ST_WB: begin
        reg_write = 1'b1;
        wb_sel    = w_is_load ? WB_MDR : WB_ALUOUT;
        retire    = 1'b1;
        w_next    = ST_FETCH;
      end

      ST_BRANCH: begin
        alu_a_sel = A_RS1;
        alu_b_sel = B_RS2;
        alu_op    = ALU_BRCMP;
        if (branch_taken) begin
          pc_write = 1'b1;
          pc_src   = PC_ALUOUT;
        end
        retire = 1'b1;
        w_next = ST_FETCH;
      end

      ST_JUMP: begin
        reg_write = 1'b1;
        wb_sel    = WB_PC;
        pc_write  = 1'b1;
        if (w_opc == OPC_JALR) begin
          // rs1 + imm computed now; the datapath clears bit 0 of the target.
          alu_a_sel = A_RS1;
          alu_b_sel = B_IMM;
          pc_src    = PC_ALU;
        end else begin
          pc_src    = PC_ALUOUT;
        end
        retire = 1'b1;
        w_next = ST_FETCH;
      end

      ST_TRAP: begin
        w_next = ST_TRAP;
      end

      default: begin
        w_next = ST_FETCH;
      end
    endcase
  end

  // A wait is a cycle with an outstanding request and no ready.
  assign w_waiting = mem_req && !mem_ready;
  assign w_clear   = (w_next != r_state) &&
                     ((w_next == ST_FETCH) || (w_next == ST_MEM));

  mc_mem_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TO_W        (TO_W)
  ) u_mem_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_clear),
    .waiting (w_waiting),
    .expired (w_expired)
  );

  assign state      = r_state;
  assign trap       = (w_state_eff == ST_TRAP);
  assign trap_cause = r_trap_cause;

`ifdef MC_CTRL_PERF_EN
  logic [CNT_W-1:0] r_perf_cycles;
  logic [CNT_W-1:0] r_perf_retired;

  // Free-running cycle and retire counters; both wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_cycles  <= '0;
      r_perf_retired <= '0;
    end else begin
      if (r_state != ST_TRAP) begin
        r_perf_cycles <= r_perf_cycles + 1'b1;
      end
      if (retire) begin
        r_perf_retired <= r_perf_retired + 1'b1;
      end
    end
  end

  assign perf_cycles  = r_perf_cycles;
  assign perf_retired = r_perf_retired;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: directed-vector bench for mc_control_fsm.
// Each cycle the inputs are driven 1 ns after the rising edge and all outputs
// are compared 1 ns later against hand-computed per-state values.
module tb_mc_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        mem_ready;
  logic        branch_taken;
  logic        mem_req, mem_we, addr_sel, ir_write, pc_write;
  logic [1:0]  pc_src, alu_a_sel, alu_b_sel, alu_op;
  logic        reg_write;
  logic [1:0]  wb_sel;
  logic        retire, trap;
  logic [1:0]  trap_cause;
  logic [2:0]  state;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] perf_cycles, perf_retired;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mc_control_fsm #(
    .MEM_TIMEOUT (16),
    .TO_W        (5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr        (instr),
    .mem_ready    (mem_ready),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .addr_sel     (addr_sel),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .alu_a_sel    (alu_a_sel),
    .alu_b_sel    (alu_b_sel),
    .alu_op       (alu_op),
    .reg_write    (reg_write),
    .wb_sel       (wb_sel),
    .retire       (retire),
    .trap         (trap),
    .trap_cause   (trap_cause),
    .state        (state)
`ifdef MC_CTRL_PERF_EN
    ,
    .perf_cycles  (perf_cycles),
    .perf_retired (perf_retired)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One comparison of every control output plus the state, field by field.
  task automatic expect_cyc(input string tag, input logic [2:0] st,
                            input logic mreq, input logic mwe, input logic asel,
                            input logic irw, input logic pcw, input logic [1:0] pcs,
                            input logic [1:0] a, input logic [1:0] b, input logic [1:0] op,
                            input logic rw, input logic [1:0] wbs, input logic ret,
                            input logic trp, input logic [1:0] tc);
    check(tag,
          {9'd0, state, mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src,
           alu_a_sel, alu_b_sel, alu_op, reg_write, wb_sel, retire, trap, trap_cause},
          {9'd0, st, mreq, mwe, asel, irw, pcw, pcs, a, b, op, rw, wbs, ret, trp, tc});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rdy, input logic tk);
    mem_ready    = rdy;
    branch_taken = tk;
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Zero-wait FETCH followed by DECODE of a legal instruction.
  task automatic fetch_decode(input string tag);
    drive(1'b1, 1'b0);
    expect_cyc({tag, "_fetch"}, 3'd0, 1,0,0, 1,1,2'd0, 2'd1,2'd2,2'd0, 0,2'd0,0, 0,2'd0);
    tick();
    drive(1'b1, 1'b0);
    expect_cyc({tag, "_decode"}, 3'd1, 0,0,0, 0,0,2'd0, 2'd2,2'd1,2'd0, 0,2'd0,0, 0,2'd0);
    tick();
  endtask

  initial begin
    instr        = 32'h0;
    mem_ready    = 1'b0;
    branch_taken = 1'b0;
    rst_n        = 1'b0;
    tick();
    tick();

    // Reset cycle: FETCH selects, request held low.
    drive(1'b0, 1'b0);
    expect_cyc("reset", 3'd0, 0,0,0, 0,0,2'd0, 2'd1,2'd2,2'd0, 0,2'd0,0, 0,2'd0);
    tick();
    rst_n = 1'b1;

    // add x3,x1,x2: F D E WB, memory ready held high throughout.
    instr = 32'h002081B3;
    fetch_decode("add");
    drive(1'b1, 1'b0);
    expect_cyc("add_exec", 3'd2, 0,0,0, 0,0,2'd0, 2'd0,2'd0,2'd2, 0,2'd0,0, 0,2'd0);
    tick();
    drive(1'b1, 1'b0);
    expect_cyc("add_wb", 3'd4, 0,0,0, 0,0,2'd0, 2'd0,2'd0,2'd0, 1,2'd0,1, 0,2'd0);
    tick();
    drive(1'b0, 1'b0);
    expect_cyc("add_next_fetch", 3'd0, 1,0,0, 0,0,2'd0, 2'd1,2'd2,2'd0, 0,2'd0,0, 0,2'd0);

    // lw x3,0(x1) with two MEM wait cycles: 7 cycles total.
    instr = 32'h0000A183;
    fetch_decode("lw");
    drive(1'b1, 1'b0);
    expect_cyc("lw_exec", 3'd2, 0,0,0, 0,0,2'd0, 2'd0,2'd1,2'd0, 0,2'd0,0, 0,2'd0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0);
      expect_cyc("lw_mem_wait", 3'd3, 1,0,1, 0,0,2'd0, 2'd0,2'd0,2'd0, 0,2'd0,0, 0,2'd0);
      tick();
    end
    drive(1'b1, 1'b0);
    expect_cyc("lw_mem_ready", 3'd3, 1,0,1, 0,0,2'd0, 2'd0,2'd0,2'd0, 0,2'd0,0, 0,2'd0);
    tick();
    drive(1'b1, 1'b0);
    expect_cyc("lw_wb", 3'd4, 0,0,0, 0,0,2'd0, 2'd0,2'd0,2'd0, 1,2'd1,1, 0,2'd0);
    tick();

    // sw x2,0(x1): retires from MEM.
    instr = 32'h0020A023;
    fetch_decode("sw");
    drive(1'b1, 1'b0);
    expect_cyc("sw_exec", 3'd2, 0,0,0, 0,0,2'd0, 2'd0,2'd1,2'd0, 0,2'd0,0, 0,2'd0);
    tick();
    drive(1'b1, 1'b0);
    expect_cyc("sw_mem", 3'd3, 1,1,1, 0,0,2'd0, 2'd0,2'd0,2'd0, 0,2'd0,1, 0,2'd0);
    tick();
    drive(1'b0, 1'b0);
    check("sw_back_to_fetch", {29'd0, state}, 32'd0);

    // beq taken, then not taken.
    instr = 32'h00208063;
    fetch_decode("beq_t");
    drive(1'b1, 1'b1);
    expect_cyc("beq_taken", 3'd5, 0,0,0, 0,1,2'd1, 2'd0,2'd0,2'd1, 0,2'd0,1, 0,2'd0);
    tick();
    fetch_decode("beq_nt");
    drive(1'b1, 1'b0);
    expect_cyc("beq_not_taken", 3'd5, 0,0,0, 0,0,2'd0, 2'd0,2'd0,2'd1, 0,2'd0,1, 0,2'd0);
    tick();

    // jal and jalr.
    instr = 32'h0000006F;
    fetch_decode("jal");
    drive(1'b1, 1'b0);
    expect_cyc("jal_jump", 3'd6, 0,0,0, 0,1,2'd1, 2'd0,2'd0,2'd0, 1,2'd2,1, 0,2'd0);
    tick();
    instr = 32'h00008067;
    fetch_decode("jalr");
    drive(1'b1, 1'b0);
    expect_cyc("jalr_jump", 3'd6, 0,0,0, 0,1,2'd0, 2'd0,2'd1,2'd0, 1,2'd2,1, 0,2'd0);
    tick();

    // lui, auipc, addi EXEC selects.
    instr = 32'h000010B7;
    fetch_decode("lui");
    drive(1'b1, 1'b0);
    expect_cyc("lui_exec", 3'd2, 0,0,0, 0,0,2'd0, 2'd3,2'd1,2'd0, 0,2'd0,0, 0,2'd0);
    tick();
    drive(1'b1, 1'b0);
    expect_cyc("lui_wb", 3'd4, 0,0,0, 0,0,2'd0, 2'd0,2'd0,2'd0, 1,2'd0,1, 0,2'd0);
    tick();
    instr = 32'h00001097;
    fetch_decode("auipc");
    drive(1'b1, 1'b0);
    expect_cyc("auipc_exec", 3'd2, 0,0,0, 0,0,2'd0, 2'd2,2'd1,2'd0, 0,2'd0,0, 0,2'd0);
    tick();
    tick();
    instr = 32'h00108093;
    fetch_decode("addi");
    drive(1'b1, 1'b0);
    expect_cyc("addi_exec", 3'd2, 0,0,0, 0,0,2'd0, 2'd0,2'd1,2'd2, 0,2'd0,0, 0,2'd0);
    tick();
    tick();

    // Illegal opcode 0x7F: trap cause 1, quiet for 20 cycles despite mem_ready.
    instr = 32'h0000007F;
    fetch_decode("illegal");
    for (int i = 0; i < 20; i++) begin
      drive(1'(i % 2), 1'b1);
      expect_cyc("trap_hold", 3'd7, 0,0,0, 0,0,2'd0, 2'd0,2'd0,2'd0, 0,2'd0,0, 1,2'd1);
      tick();
    end
    do_reset();
    drive(1'b0, 1'b0);
    expect_cyc("trap_reset_exit", 3'd0, 1,0,0, 0,0,2'd0, 2'd1,2'd2,2'd0, 0,2'd0,0, 0,2'd0);

    // FETCH timeout: 16 wait cycles, then TRAP cause 2.
    instr = 32'h002081B3;
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0);
      expect_cyc("to_fetch_wait", 3'd0, 1,0,0, 0,0,2'd0, 2'd1,2'd2,2'd0, 0,2'd0,0, 0,2'd0);
      tick();
    end
    drive(1'b0, 1'b0);
    expect_cyc("to_fetch_trap", 3'd7, 0,0,0, 0,0,2'd0, 2'd0,2'd0,2'd0, 0,2'd0,0, 1,2'd2);

    // Ready on the 16th cycle completes the fetch with no trap.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 1'b0);
    expect_cyc("to_late_ready", 3'd0, 1,0,0, 1,1,2'd0, 2'd1,2'd2,2'd0, 0,2'd0,0, 0,2'd0);
    tick();
    drive(1'b0, 1'b0);
    check("to_late_no_trap", {29'd0, state, trap, trap_cause}, {29'd0, 3'd1, 1'b0, 2'd0} >> 0);

    // Counter restarts on MEM entry: 10 FETCH waits then 15 MEM waits, no trap.
    do_reset();
    instr = 32'h0000A183;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 1'b0);
    tick();
    tick();
    tick();
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 1'b0);
    expect_cyc("mem_late_ready", 3'd3, 1,0,1, 0,0,2'd0, 2'd0,2'd0,2'd0, 0,2'd0,0, 0,2'd0);
    tick();
    drive(1'b0, 1'b0);
    expect_cyc("mem_late_wb", 3'd4, 0,0,0, 0,0,2'd0, 2'd0,2'd0,2'd0, 1,2'd1,1, 0,2'd0);

    // MEM timeout: 16 wait cycles in MEM trap with cause 2.
    do_reset();
    fetch_decode("lw_to");
    tick();
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 1'b0);
    expect_cyc("to_mem_trap", 3'd7, 0,0,0, 0,0,2'd0, 2'd0,2'd0,2'd0, 0,2'd0,0, 1,2'd2);

`ifdef MC_CTRL_PERF_EN
    // Ten addi instructions at 4 cycles each.
    do_reset();
    instr = 32'h00108093;
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 1'b0);
      tick();
    end
    check("perf_retired", perf_retired, 32'd10);
    check("perf_cycles", perf_cycles, 32'd40);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
